// File: rtl/fpu_pkg.sv
// Shared FPU dispatch definitions: opcode fields, unit indices, error codes, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fpu_pkg;

  // Opcode layout: bit0 is the modifier, bits[4:1] are a one-hot unit select.
  localparam int OPC_WIDTH   = 5;
  localparam int OPC_MOD_BIT = 0;
  localparam int OPC_SEL_LSB = 1;
  localparam int OPC_SEL_MSB = 4;

  localparam int NUM_UNITS = 4;
  localparam int UNIT_ADD  = 0;
  localparam int UNIT_MUL  = 1;
  localparam int UNIT_DIV  = 2;
  localparam int UNIT_CMP  = 3;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } disp_state_t;

endpackage

// File: rtl/fpu_op_dispatch_if.sv
// Bundle of request, unit and response signals between the dispatcher and its neighbours.
// Latency: n/a (wiring only).
// Backpressure: req_valid/req_ready on the request side, rsp_valid/rsp_ready on the response side.
// Ports: req_* (request in), unit_* (start/operands out, done/results in), rsp_* (response out), busy.
// Modport master is the dispatcher's view; slave is the environment's view.
interface fpu_op_dispatch_if #(
  parameter int WIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [4:0]           req_opcode;
  logic [WIDTH-1:0]     req_a;
  logic [WIDTH-1:0]     req_b;

  logic [3:0]           unit_start;
  logic                 unit_mod;
  logic [WIDTH-1:0]     unit_a;
  logic [WIDTH-1:0]     unit_b;
  logic [3:0]           unit_done;
  logic [4*WIDTH-1:0]   unit_result;

  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [WIDTH-1:0]     rsp_result;
  logic [1:0]           rsp_err;
  logic                 busy;

  modport master (
    input  req_valid, req_opcode, req_a, req_b, unit_done, unit_result, rsp_ready,
    output req_ready, unit_start, unit_mod, unit_a, unit_b, rsp_valid, rsp_result, rsp_err, busy
  );

  modport slave (
    output req_valid, req_opcode, req_a, req_b, unit_done, unit_result, rsp_ready,
    input  req_ready, unit_start, unit_mod, unit_a, unit_b, rsp_valid, rsp_result, rsp_err, busy
  );
endinterface

// File: rtl/fpu_op_decode.sv
// Opcode decoder: splits an FPU opcode into a one-hot unit select, modifier and legality flag.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: opcode in; sel (one-hot unit select), mod (modifier bit), legal (exactly one select bit set) out.
module fpu_op_decode
  import fpu_pkg::*;
(
  input  logic [OPC_WIDTH-1:0] opcode,
  output logic [NUM_UNITS-1:0] sel,
  output logic                 mod,
  output logic                 legal
);

  assign sel   = opcode[OPC_SEL_MSB:OPC_SEL_LSB];
  assign mod   = opcode[OPC_MOD_BIT];
  // Zero or multiple select bits is an illegal opcode.
  assign legal = $onehot(sel);

endmodule

// File: rtl/fpu_op_dispatch.sv
// Dispatcher: accepts one FPU request, pulses start to one unit, waits for done or timeout, returns a response.
// Latency: 3 cycles accept-to-rsp_valid minimum; illegal opcode 1 cycle; timeout TIMEOUT+1 cycles after start.
// Backpressure: req_ready only in IDLE; response held stable in RESP until rsp_ready.
// Ports: clk, rst (sync active-high), bus (fpu_op_dispatch_if.master: req_*, unit_*, rsp_*, busy).
module fpu_op_dispatch
  import fpu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64   // must be >= 2
)(
  input  logic              clk,
  input  logic              rst,
  fpu_op_dispatch_if.master bus
);

  localparam int              CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

  disp_state_t          state;
  logic [NUM_UNITS-1:0] sel_q;
  logic [NUM_UNITS-1:0] start_q;
  logic                 mod_q;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic [WIDTH-1:0]     result_q;
  logic [1:0]           err_q;
  logic [CW-1:0]        cnt;

  logic [NUM_UNITS-1:0] dec_sel;
  logic                 dec_mod;
  logic                 dec_legal;

  logic                 done_hit;
  logic [WIDTH-1:0]     sel_result;

  fpu_op_decode u_decode (
    .opcode (bus.req_opcode),
    .sel    (dec_sel),
    .mod    (dec_mod),
    .legal  (dec_legal)
  );

  // Only the selected unit's done counts; strays from other units fall out here.
  assign done_hit = |(bus.unit_done & sel_q);

  // sel_q is one-hot in WAIT, so OR-ing the masked slices is a plain mux.
  always_comb begin
    sel_result = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (sel_q[i]) begin
        sel_result = sel_result | bus.unit_result[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      sel_q    <= '0;
      start_q  <= '0;
      mod_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= ERR_OK;
      cnt      <= '0;
    end else begin
      start_q <= '0;
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            a_q   <= bus.req_a;
            b_q   <= bus.req_b;
            mod_q <= dec_mod;
            if (dec_legal) begin
              sel_q   <= dec_sel;
              start_q <= dec_sel;
              state   <= ST_ISSUE;
            end else begin
              sel_q    <= '0;
              err_q    <= ERR_ILLEGAL;
              result_q <= '0;
              state    <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= '0;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // Done beats a coincident timeout.
          if (done_hit) begin
            result_q <= sel_result;
            err_q    <= ERR_OK;
            state    <= ST_RESP;
          end else if (cnt == CNT_LAST) begin
            result_q <= '0;
            err_q    <= ERR_TIMEOUT;
            state    <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.rsp_valid  = (state == ST_RESP);
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;
  assign bus.unit_start = start_q;
  assign bus.unit_mod   = mod_q;
  assign bus.unit_a     = a_q;
  assign bus.unit_b     = b_q;

endmodule

// File: tb/tb_fpu_op_dispatch.sv
// Directed bench for fpu_op_dispatch: reset, legal/illegal ops, timeout, backpressure, stray done, mid-op reset.
// Latency: n/a.
// Backpressure: rsp_ready driven per step.
module tb_fpu_op_dispatch;

  localparam int W          = 32;
  localparam int TB_TIMEOUT = 16;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  fpu_op_dispatch_if #(.WIDTH(W)) bus ();

  fpu_op_dispatch #(.WIDTH(W), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [4:0] opc, input logic [31:0] a, input logic [31:0] b);
    bus.req_valid  = 1'b1;
    bus.req_opcode = opc;
    bus.req_a      = a;
    bus.req_b      = b;
    step();
    bus.req_valid  = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_opcode  = '0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.unit_done   = '0;
    bus.unit_result = '0;
    bus.rsp_ready   = 1'b0;

    // Reset
    step();
    step();
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_unit_start", bus.unit_start, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_rsp_result", bus.rsp_result, 0);
    chk("rst_unit_a", bus.unit_a, 0);
    chk("rst_unit_b", bus.unit_b, 0);
    chk("rst_unit_mod", bus.unit_mod, 0);
    rst = 1'b0;
    step();
    chk("idle_req_ready", bus.req_ready, 1);

    // Legal subtract on the add unit, done 3 cycles after start
    send(5'b00011, 32'h3F800000, 32'h40000000);
    chk("add_start", bus.unit_start, 4'b0001);
    chk("add_mod", bus.unit_mod, 1);
    chk("add_a", bus.unit_a, 32'h3F800000);
    chk("add_b", bus.unit_b, 32'h40000000);
    chk("add_busy", bus.busy, 1);
    chk("add_req_ready", bus.req_ready, 0);
    step();
    chk("add_start_pulse", bus.unit_start, 0);
    step();
    step();
    bus.unit_done = 4'b0001;
    bus.unit_result[0*W +: W] = 32'hBF800000;
    chk("add_no_early_rsp", bus.rsp_valid, 0);
    step();
    bus.unit_done = '0;
    chk("add_rsp_valid", bus.rsp_valid, 1);
    chk("add_rsp_result", bus.rsp_result, 32'hBF800000);
    chk("add_rsp_err", bus.rsp_err, 2'b00);
    chk("add_hold_a", bus.unit_a, 32'h3F800000);
    bus.rsp_ready = 1'b1;
    step();
    chk("add_back_idle", bus.req_ready, 1);
    chk("add_rsp_drop", bus.rsp_valid, 0);

    // Illegal opcodes: no select bit, two select bits
    send(5'b00000, 32'h1, 32'h2);
    chk("ill0_start", bus.unit_start, 0);
    chk("ill0_rsp_valid", bus.rsp_valid, 1);
    chk("ill0_err", bus.rsp_err, 2'b01);
    chk("ill0_result", bus.rsp_result, 0);
    step();
    chk("ill0_idle", bus.req_ready, 1);
    send(5'b00110, 32'h3, 32'h4);
    chk("ill6_start", bus.unit_start, 0);
    chk("ill6_rsp_valid", bus.rsp_valid, 1);
    chk("ill6_err", bus.rsp_err, 2'b01);
    chk("ill6_result", bus.rsp_result, 0);
    step();
    bus.rsp_ready = 1'b0;

    // Minimum latency: done offered during ISSUE must be ignored, taken in first WAIT cycle
    send(5'b00101, 32'h40000000, 32'h40A00000);
    chk("mul_start", bus.unit_start, 4'b0010);
    bus.unit_done = 4'b0010;
    bus.unit_result[1*W +: W] = 32'hAAAA0000;
    step();
    chk("fast_no_issue_capture", bus.rsp_valid, 0);
    bus.unit_result[1*W +: W] = 32'h41200000;
    step();
    bus.unit_done = '0;
    chk("fast_rsp_valid", bus.rsp_valid, 1);
    chk("fast_rsp_result", bus.rsp_result, 32'h41200000);
    chk("fast_rsp_err", bus.rsp_err, 2'b00);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Timeout on mul with no done
    send(5'b00100, 32'h11111111, 32'h22222222);
    chk("to_start", bus.unit_start, 4'b0010);
    for (int k = 1; k <= TB_TIMEOUT; k++) begin
      step();
      chk("to_not_yet", bus.rsp_valid, 0);
    end
    step();
    chk("to_rsp_valid", bus.rsp_valid, 1);
    chk("to_rsp_err", bus.rsp_err, 2'b10);
    chk("to_rsp_result", bus.rsp_result, 0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    bus.unit_done = 4'b0010;
    bus.unit_result[1*W +: W] = 32'h12345678;
    step();
    bus.unit_done = '0;
    chk("late_done_rsp", bus.rsp_valid, 0);
    chk("late_done_busy", bus.busy, 0);
    chk("late_done_ready", bus.req_ready, 1);

    // Backpressure with a stray done from the wrong unit
    send(5'b01000, 32'h40C00000, 32'h40000000);
    chk("div_start", bus.unit_start, 4'b0100);
    step();
    bus.unit_done = 4'b0001;
    bus.unit_result[0*W +: W] = 32'hDEADBEEF;
    step();
    chk("stray_ignored", bus.rsp_valid, 0);
    bus.unit_done = 4'b0100;
    bus.unit_result[2*W +: W] = 32'h40400000;
    step();
    bus.unit_done = '0;
    chk("div_rsp_valid", bus.rsp_valid, 1);
    chk("div_rsp_result", bus.rsp_result, 32'h40400000);
    chk("div_rsp_err", bus.rsp_err, 2'b00);
    // Repeat done during RESP must not disturb the held response
    bus.unit_done = 4'b0100;
    bus.unit_result[2*W +: W] = 32'h00000BAD;
    for (int k = 0; k < 5; k++) begin
      step();
      bus.unit_done = '0;
      chk("bp_valid", bus.rsp_valid, 1);
      chk("bp_result", bus.rsp_result, 32'h40400000);
      chk("bp_err", bus.rsp_err, 2'b00);
      chk("bp_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("bp_release_idle", bus.req_ready, 1);
    chk("bp_release_valid", bus.rsp_valid, 0);

    // Reset while waiting on the add unit
    send(5'b00010, 32'h3F000000, 32'h3F000000);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_ready", bus.req_ready, 1);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_rsp_valid", bus.rsp_valid, 0);
    chk("mrst_start", bus.unit_start, 0);
    bus.unit_done = 4'b0001;
    bus.unit_result[0*W +: W] = 32'h3F800000;
    step();
    bus.unit_done = '0;
    chk("mrst_late_done", bus.rsp_valid, 0);
    chk("mrst_late_idle", bus.req_ready, 1);

    // Fresh signed compare after the reset
    send(5'b10001, 32'hBF800000, 32'h3F800000);
    chk("cmp_start", bus.unit_start, 4'b1000);
    chk("cmp_mod", bus.unit_mod, 1);
    step();
    bus.unit_done = 4'b1000;
    bus.unit_result[3*W +: W] = 32'h00000001;
    step();
    bus.unit_done = '0;
    chk("cmp_rsp_valid", bus.rsp_valid, 1);
    chk("cmp_rsp_result", bus.rsp_result, 32'h00000001);
    chk("cmp_rsp_err", bus.rsp_err, 2'b00);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("cmp_done_idle", bus.req_ready, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
